// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm snooze controller: FSM state encoding and timer width.
package alarm_pkg;

    localparam int TIMER_W = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

endpackage

// File: rtl/alarm_sec_timer.sv
// Seconds counter that restarts on clear and flags the tick that completes the programmed limit.
module alarm_sec_timer
    import alarm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               clear,
    input  logic [TIMER_W-1:0] limit,
    output logic               expire
);

    logic [TIMER_W-1:0] count;
    logic [TIMER_W-1:0] terminal;

    assign terminal = limit - TIMER_W'(1);
    assign expire   = tick && (count == terminal);

    // Clear wins over a coincident tick so a fresh state always starts at zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ring/snooze controller: rings on an armed alarm edge, supports limited snoozes and ring timeout.
module alarm_snooze_ctrl
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       alarm_in,
    input  logic       enable,
    input  logic       snooze_btn,
    input  logic       dismiss_btn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_count,
    output logic       missed
);

    localparam logic [TIMER_W-1:0] SNOOZE_LIM = TIMER_W'(SNOOZE_SEC);
    localparam logic [TIMER_W-1:0] RING_LIM   = TIMER_W'(RING_TIMEOUT_SEC);
    localparam logic [1:0]         MAX_CNT    = 2'(MAX_SNOOZE);

    state_t             state;
    state_t             state_next;
    logic               alarm_q;
    logic               trigger;
    logic               snooze_ok;
    logic               timed_out;
    logic               expire;
    logic [TIMER_W-1:0] limit;

    assign limit     = (state == SNOOZE) ? SNOOZE_LIM : RING_LIM;
    assign trigger   = (state == IDLE) && enable && alarm_in && !alarm_q;
    assign snooze_ok = snooze_count < MAX_CNT;

    alarm_sec_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .tick   (sec_tick),
        .clear  (state_next != state),
        .limit  (limit),
        .expire (expire)
    );

    // Priority: enable low, then dismiss, then snooze, then timer expiry.
    always_comb begin
        state_next = state;
        timed_out  = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) state_next = RING;
                end
                RING: begin
                    if (dismiss_btn) begin
                        state_next = IDLE;
                    end else if (snooze_btn && snooze_ok) begin
                        state_next = SNOOZE;
                    end else if (expire) begin
                        state_next = IDLE;
                        timed_out  = 1'b1;
                    end
                end
                SNOOZE: begin
                    if (dismiss_btn) begin
                        state_next = IDLE;
                    end else if (expire) begin
                        state_next = RING;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // alarm_q resets high so a level already present at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            alarm_q      <= 1'b1;
            buzzer       <= 1'b0;
            ringing      <= 1'b0;
            snoozing     <= 1'b0;
            snooze_count <= 2'd0;
            missed       <= 1'b0;
        end else begin
            state    <= state_next;
            alarm_q  <= alarm_in;
            ringing  <= (state_next == RING);
            snoozing <= (state_next == SNOOZE);

            if (state_next != RING) begin
                buzzer <= 1'b0;
            end else if (state != RING) begin
                buzzer <= 1'b1;
            end else if (sec_tick) begin
                buzzer <= ~buzzer;
            end

            if (trigger) begin
                snooze_count <= 2'd0;
            end else if (state == RING && state_next == SNOOZE) begin
                snooze_count <= snooze_count + 2'd1;
            end

            if (trigger || (state == IDLE && enable && dismiss_btn)) begin
                missed <= 1'b0;
            end else if (timed_out) begin
                missed <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alarm_snooze_ctrl.md
ALARM_SNOOZE_CTRL -- requirements
Module: alarm_snooze_ctrl

Interface
REQ-001 Parameter SNOOZE_SEC, default 300, snooze length in sec_tick pulses; legal range 1..511.
REQ-002 Parameter RING_TIMEOUT_SEC, default 60, unattended ring length in sec_tick pulses; legal range 1..511.
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event; legal range 0..3.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sec_tick  input  1  one-cycle pulse per elapsed second.
REQ-007 alarm_in  input  1  time-match level from the clock block.
REQ-008 enable  input  1  alarm armed switch.
REQ-009 snooze_btn  input  1  debounced one-cycle press pulse.
REQ-010 dismiss_btn  input  1  debounced one-cycle press pulse.
REQ-011 buzzer  output  1  audible drive, 1 s on / 1 s off cadence.
REQ-012 ringing  output  1  high in state RING.
REQ-013 snoozing  output  1  high in state SNOOZE.
REQ-014 snooze_count  output  2  snoozes used in current alarm event.
REQ-015 missed  output  1  sticky flag: last event ended by ring timeout.

Function
REQ-016 FSM states SHALL be IDLE, RING, SNOOZE; all outputs registered; state changes one cycle after the causing input.
REQ-017 Trigger SHALL be rising edge of alarm_in (alarm_in=1, registered alarm_q=0) while enable=1 in IDLE -> RING; snooze_count<=0, missed<=0, timer<=0.
REQ-018 alarm_in edges in RING or SNOOZE SHALL be ignored.
REQ-019 Single 9-bit timer SHALL increment on sec_tick, clear on every state entry; "expiry" = sec_tick while timer == limit-1.
REQ-020 RING: dismiss_btn -> IDLE; else snooze_btn with snooze_count<MAX_SNOOZE -> SNOOZE, snooze_count+1; else expiry at RING_TIMEOUT_SEC -> IDLE, missed<=1.
REQ-021 RING: snooze_btn with snooze_count==MAX_SNOOZE SHALL be ignored (ringing continues).
REQ-022 SNOOZE: dismiss_btn -> IDLE; else expiry at SNOOZE_SEC -> RING; snooze_btn ignored.
REQ-023 enable=0 SHALL force IDLE from any state next cycle, missed unchanged; highest priority.
REQ-024 Priority per cycle SHALL be enable=0 > dismiss_btn > snooze_btn > expiry.
REQ-025 buzzer SHALL be 1 on RING entry, toggle on each sec_tick in RING, 0 in IDLE/SNOOZE.
REQ-026 missed SHALL clear on dismiss_btn in IDLE or on a new trigger.
REQ-027 snooze_count SHALL hold in IDLE until the next trigger.

Reset
REQ-028 reset SHALL set state IDLE, timer 0, buzzer 0, ringing 0, snoozing 0, snooze_count 0, missed 0.
REQ-029 reset SHALL set alarm_q to 1 so alarm_in high at reset release does not trigger.
REQ-030 reset mid-RING or mid-SNOOZE SHALL abort the event with no missed flag.

Structure
REQ-031 Shared package alarm_pkg SHALL hold the state enum (IDLE, RING, SNOOZE) and timer width constant (9).
REQ-032 The tick counter with clear and terminal compare SHALL be sub-module alarm_sec_timer.

Verification (SNOOZE_SEC=5, RING_TIMEOUT_SEC=4, MAX_SNOOZE=2)
REQ-033 alarm_in 0->1, enable=1 -> ringing=1, buzzer=1 next cycle; buzzer toggles 1,0,1,0 over 4 ticks; after 4th tick ringing=0, missed=1.
REQ-034 Ring, snooze_btn -> snoozing=1, snooze_count=1; 5 ticks -> ringing=1, buzzer=1.
REQ-035 Ring, snooze twice, third snooze_btn in RING -> stays RING, snooze_count=2.
REQ-036 snooze_btn and dismiss_btn same cycle in RING -> IDLE, snooze_count unchanged, missed=0.
REQ-037 enable dropped in SNOOZE -> IDLE next cycle; alarm_in high during reset release -> no ring.
